bus_reassembler: RTL
====================

# bus_reassembler

Receive-side counterpart of the bus word splitter. Accepts the word-reversed bus and its per-word control flags, restores the original word order, and collects words across one or more input beats until every lane is filled. It then presents the complete bus downstream with a valid/ready handshake and counts duplicate-lane errors. It sits between the word-managing stage output and the downstream bus consumer.

## Interface
- BUS_SIZE, 16, total bus width in bits
- WORD_SIZE, 4, word width in bits; BUS_SIZE must be an integer multiple
- WORD_NUM, BUS_SIZE/WORD_SIZE, lane count (derived, not overridden)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- data_in  in  BUS_SIZE  word-reversed bus; lane i word = data_in[(BUS_SIZE-1)-i*WORD_SIZE -: WORD_SIZE]
- control_in  in  WORD_NUM  control_in[i]=1 marks lane i word as present this beat
- valid_in  in  1  upstream beat valid
- ready_out  out  1  block accepts a beat this cycle
- data_out  out  BUS_SIZE  reassembled bus; lane i at data_out[i*WORD_SIZE +: WORD_SIZE]
- valid_out  out  1  data_out holds a complete bus
- ready_in  in  1  downstream accepts data_out
- lane_mask  out  WORD_NUM  lanes filled so far
- err_dup  out  1  one-cycle pulse: beat hit an already-filled lane
- err_count  out  8  saturating duplicate-beat counter

## Operation
- States: COLLECT, HOLD. Reset state COLLECT.
- Reset values: data_out=0, valid_out=0, lane_mask=0, err_dup=0, err_count=0, ready_out=1.
- ready_out = (state==COLLECT); decoded from state only, no combinational path from inputs.
- COLLECT, beat accepted when valid_in=1: for each lane i with control_in[i]=1:
  - lane_mask[i]=0: store word into data_out lane i, set lane_mask[i].
  - lane_mask[i]=1: duplicate; stored word kept, new word dropped.
- Any duplicate lane in a beat: err_dup=1 next cycle; err_count +1 per beat (not per lane), saturates at 255.
- Non-duplicate lanes of a duplicate beat are still stored.
- valid_in=1 with control_in=0: no state change.
- Updated lane_mask all ones: transition to HOLD, valid_out=1.
- HOLD: data_out, lane_mask stable; valid_in ignored (ready_out=0), no errors counted.
- HOLD with ready_in=1: lane_mask cleared, valid_out=0, return to COLLECT. data_out keeps the last value until overwritten lane by lane.
- valid_in ignored while valid_out=1, even when ready_in=1 in that cycle.

## Timing
- Beat completing the bus sampled at edge k: valid_out=1 and data_out complete after edge k (zero wait states).
- Handshake (valid_out & ready_in) at edge m: valid_out=0, ready_out=1 after edge m; next beat accepted at edge m+1 earliest.
- Single-beat full bus (control_in all ones in COLLECT): one cycle in, output after the same edge.
- Throughput: at most one bus per two cycles.
- err_dup is registered: high exactly one cycle after the offending edge.
- A beat that completes the bus and also hits a duplicate lane completes the bus and raises err_dup.
- Reset assertion at any time: immediate return to reset values, partial lanes discarded, err_count cleared.

## Test plan
- Single beat: data_in=16'h4321, control_in=4'hF, valid_in=1 -> next cycle valid_out=1, data_out=16'h1234, lane_mask=4'hF; ready_in=1 -> valid_out=0, ready_out=1, lane_mask=0.
- Two-beat assembly: data_in=16'hAB00/ctrl 4'b0011, then data_in=16'h00CD/ctrl 4'b1100 -> lane_mask 4'b0011 after beat 1; valid_out=1 and data_out=16'hDCBA after beat 2.
- Duplicate: data_in=16'h5000/ctrl 4'b0001, then 16'h6000/ctrl 4'b0001 -> err_dup one-cycle pulse, err_count=1, lane 0 holds 4'h5, lane_mask=4'b0001.
- Backpressure: complete bus 16'h8765/ctrl 4'hF, ready_in=0 for 3 cycles while valid_in=1 with 16'hFFFF/ctrl 4'hF -> data_out stays 16'h5678, ready_out=0, no err_dup; ready_in=1 -> release, next beat accepted.
- Reset mid-collect: beat 16'h9000/ctrl 4'b0001, then reset low for 1 cycle -> lane_mask=0, err_count=0, valid_out=0; full beat after reset yields only the new data.
- Saturation: 300 duplicate beats -> err_count holds 255, err_dup pulses for every duplicate beat.

Source files
------------

// File: rtl/bus_reassembler.sv
// bus_reassembler: restores word order of a word-reversed bus, collects lanes
// across beats until all are filled, then offers the full bus downstream with
// a valid/ready handshake. Duplicate-lane beats are flagged and counted.
module bus_reassembler #(
    parameter int unsigned BUS_SIZE  = 16,
    parameter int unsigned WORD_SIZE = 4,
    localparam int unsigned WORD_NUM = BUS_SIZE / WORD_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BUS_SIZE-1:0] data_in,
    input  logic [WORD_NUM-1:0] control_in,
    input  logic                valid_in,
    output logic                ready_out,
    output logic [BUS_SIZE-1:0] data_out,
    output logic                valid_out,
    input  logic                ready_in,
    output logic [WORD_NUM-1:0] lane_mask,
    output logic                err_dup,
    output logic [7:0]          err_count
);

    typedef enum logic [0:0] {StCollect, StHold} state_e;

    state_e              state_q, state_d;
    logic [BUS_SIZE-1:0] data_d;
    logic [WORD_NUM-1:0] mask_d;
    logic                dup_d;
    logic [7:0]          count_d;

    // Handshake flags decode the state only, so ready_out has no input path.
    assign ready_out = (state_q == StCollect);
    assign valid_out = (state_q == StHold);

    // Next-state: lane merge, duplicate detection and handshake release.
    always_comb begin
        state_d = state_q;
        data_d  = data_out;
        mask_d  = lane_mask;
        dup_d   = 1'b0;
        count_d = err_count;
        unique case (state_q)
            StCollect: begin
                if (valid_in) begin
                    for (int i = 0; i < WORD_NUM; i++) begin
                        if (control_in[i]) begin
                            if (lane_mask[i]) begin
                                // Already filled: keep the stored word.
                                dup_d = 1'b1;
                            end else begin
                                data_d[i*WORD_SIZE +: WORD_SIZE] =
                                    data_in[(BUS_SIZE-1)-i*WORD_SIZE -: WORD_SIZE];
                                mask_d[i] = 1'b1;
                            end
                        end
                    end
                    // One count per offending beat, not per lane.
                    if (dup_d && (err_count != 8'hFF)) begin
                        count_d = err_count + 8'd1;
                    end
                    if (&mask_d) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                // data_out is left as is; lanes get overwritten one by one later.
                if (ready_in) begin
                    mask_d  = '0;
                    state_d = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StCollect;
            data_out  <= '0;
            lane_mask <= '0;
            err_dup   <= 1'b0;
            err_count <= '0;
        end else begin
            state_q   <= state_d;
            data_out  <= data_d;
            lane_mask <= mask_d;
            err_dup   <= dup_d;
            err_count <= count_d;
        end
    end

endmodule
